// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for the decode stage.
// Each register carries a counter giving the cycles left until its pending
// result becomes forwardable. Stall/issue are derived combinationally from
// that state and the current decode-stage instruction.
module hazard_scoreboard #(
   parameter int unsigned NREGS   = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MAX_LAT = 4,
   parameter int unsigned LAT_W   = 3,
   parameter int unsigned STAT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,        // synchronous, active low
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_use_rs,
   input  logic              i_id_use_rt,
   input  logic              i_id_wr_en,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic [LAT_W-1:0]  i_id_lat,
   input  logic              i_mem_wait,
   input  logic              i_flush,
   output logic              o_stall,
   output logic              o_issue,
   output logic [NREGS-1:0]  o_busy,
   output logic [STAT_W-1:0] o_stall_cnt
);

   localparam logic [LAT_W-1:0] LP_MAX_LAT = LAT_W'(MAX_LAT);

   logic [LAT_W-1:0]  r_cnt [NREGS];
   logic [STAT_W-1:0] r_stall_cnt;

   logic [LAT_W-1:0]  w_rs_cnt;
   logic [LAT_W-1:0]  w_rt_cnt;
   logic [LAT_W-1:0]  w_rd_cnt;
   logic [LAT_W-1:0]  w_eff_lat;
   logic              w_raw;
   logic              w_waw;
   logic              w_track;
   logic              w_stall;
   logic              w_issue;

   // Indices beyond the register file read as "not pending".
   assign w_rs_cnt  = (32'(i_id_rs) < NREGS) ? r_cnt[i_id_rs] : '0;
   assign w_rt_cnt  = (32'(i_id_rt) < NREGS) ? r_cnt[i_id_rt] : '0;
   assign w_rd_cnt  = (32'(i_id_rd) < NREGS) ? r_cnt[i_id_rd] : '0;
   assign w_eff_lat = (32'(i_id_lat) > MAX_LAT) ? LP_MAX_LAT : i_id_lat;

   assign w_track = i_id_wr_en && (i_id_rd != '0) && (32'(i_id_rd) < NREGS);
   assign w_raw   = (i_id_use_rs && (w_rs_cnt != '0)) || (i_id_use_rt && (w_rt_cnt != '0));
   // A younger writer must not finish before an older one to the same register.
   assign w_waw   = w_track && (w_rd_cnt > w_eff_lat);

   assign w_stall = i_rst && (i_mem_wait || (i_id_valid && !i_flush && (w_raw || w_waw)));
   assign w_issue = i_rst && i_id_valid && !i_flush && !w_stall;

   assign o_stall     = w_stall;
   assign o_issue     = w_issue;
   assign o_stall_cnt = r_stall_cnt;

   // Countdown per register: reset clears, mem_wait freezes, issue reloads.
   always_ff @(posedge i_clk) begin
      r_cnt[0] <= '0;
      if (!i_rst) begin
         for (int r = 1; r < int'(NREGS); r++) begin
            r_cnt[r] <= '0;
         end
      end else if (!i_mem_wait) begin
         for (int r = 1; r < int'(NREGS); r++) begin
            if (w_issue && w_track && (i_id_rd == REG_AW'(r))) begin
               r_cnt[r] <= w_eff_lat;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
   end

   // Busy flags decoded from the counters.
   always_comb begin
      o_busy = '0;
      for (int r = 0; r < int'(NREGS); r++) begin
         o_busy[r] = (r_cnt[r] != '0);
      end
   end

endmodule
